// File: rtl/param_seq_detect_if.sv
// ----------------------------------------------------------------------------
// param_seq_detect_if
//   Groups the serial stream, the pattern configuration and the detector
//   status signals of param_seq_detect.
//   master : the stream/config source (drives data, pattern, control)
//   slave  : the detector (drives match, match_cnt, cfg_err, armed)
// Signals
//   data_valid, data_in          serial stream and its qualifier
//   pat_load, pat_in, len_in     pattern load strobe, pattern, length
//   overlap_en, cnt_clr          detection mode, match counter clear
//   match, match_cnt             match pulse, saturating match count
//   cfg_err, armed               illegal-length pulse, legal pattern loaded
// ----------------------------------------------------------------------------
interface param_seq_detect_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               data_valid;
    logic               data_in;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               overlap_en;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;
    logic               armed;

    modport master (
        output data_valid, data_in, pat_load, pat_in, len_in, overlap_en, cnt_clr,
        input  match, match_cnt, cfg_err, armed
    );

    modport slave (
        input  data_valid, data_in, pat_load, pat_in, len_in, overlap_en, cnt_clr,
        output match, match_cnt, cfg_err, armed
    );
endinterface

// File: rtl/param_seq_detect.sv
// ----------------------------------------------------------------------------
// param_seq_detect
//   Run-time programmable serial sequence detector. A pattern of 1..MAX_LEN
//   bits is compared against the most recent valid input bits; a registered
//   one-cycle match pulse follows the edge that sampled the last pattern bit.
//   Overlapping or non-overlapping detection is selected by overlap_en, and
//   matches are tallied in a saturating counter.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    param_seq_detect_if.slave (stream, config, status)
// ----------------------------------------------------------------------------
module param_seq_detect #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    param_seq_detect_if.slave  bus
);

    typedef enum logic [1:0] {
        UNCONF = 2'd0,   // no legal pattern yet, stream ignored
        FILL   = 2'd1,   // fewer than len bits collected since restart
        HUNT   = 2'd2    // history full, every valid bit may complete a match
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q,   pat_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [MAX_LEN-1:0] hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               armed_q, armed_d;
    logic               match_q, cfg_err_q;

    logic               legal_len;
    logic               load_ok;
    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic               fill_ready;
    logic               hit;

    // Compare datapath: the candidate window includes the bit arriving now,
    // so a hit is known on the same edge that samples the last pattern bit.
    always_comb begin
        legal_len  = (bus.len_in != '0) && (bus.len_in <= LEN_W'(MAX_LEN));
        load_ok    = bus.pat_load && legal_len;
        cand       = {hist_q[MAX_LEN-2:0], bus.data_in};
        fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
        fill_ready = (fill_inc >= {1'b0, len_q});
        mask       = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        // A legal load on the same edge discards the incoming bit.
        hit = bus.data_valid && !load_ok && (state_q != UNCONF) &&
              fill_ready && (((cand ^ pat_q) & mask) == '0);
    end

    // Next-state / next-config logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;

        if (load_ok) begin
            pat_d   = bus.pat_in;
            len_d   = bus.len_in;
            hist_d  = '0;
            fill_d  = '0;
            armed_d = 1'b1;
            state_d = FILL;
        end else begin
            unique case (state_q)
                FILL, HUNT: begin
                    if (bus.data_valid) begin
                        hist_d = cand;
                        if (hit && !bus.overlap_en) begin
                            // Non-overlapping: the next match needs len fresh bits.
                            fill_d  = '0;
                            state_d = FILL;
                        end else if (fill_ready) begin
                            fill_d  = len_q;
                            state_d = HUNT;
                        end else begin
                            fill_d  = fill_inc[LEN_W-1:0];
                            state_d = FILL;
                        end
                    end
                end
                default: ;  // UNCONF: stream ignored until a legal load
            endcase
        end

        // Clear and a coincident hit collapse to a count of one.
        if (bus.cnt_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: history is a plain shift register and is reset with everything
    // else, so detection after reset can never see stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UNCONF;
            pat_q     <= '0;
            len_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            match_q   <= hit;
            cfg_err_q <= bus.pat_load && !legal_len;
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.armed     = armed_q;

endmodule
